// File: rtl/ripple_carry_adder.sv
// ============================================================================
// Module      : ripple_carry_adder
// Description : WIDTH-bit ripple-carry adder built from a chain of 1-bit full
//               adders. The sum and every stage carry-out are registered, so
//               results appear one clock after the operands are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  // w_c[i] is the carry into stage i; w_c[i+1] is the carry out of stage i.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_co;

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_cout;

  assign w_c[0] = cin;

  // One full adder per bit; the chain is purely combinational.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic w_p;
    assign w_p      = a[i] ^ b[i];
    assign w_s[i]   = w_p ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & w_p);
  end

  // Per-stage carry-outs exposed as a vector; top bit is the final carry.
  assign w_co = w_c[WIDTH:1];

  // Register the result every cycle; reset wins over the adder output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= '0;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_co;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
// ============================================================================
// Module      : tb_ripple_carry_adder
// Description : Scoreboard bench for ripple_carry_adder. A driver applies
//               operands and queues the expected registered result; a monitor
//               pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_carry_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic [W-1:0] cout;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard queues, one entry per rising edge after the first drive.
  logic [W-1:0] q_sum  [$];
  logic [W-1:0] q_cout [$];
  string        q_name [$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: unsigned arithmetic. The carry out of stage i is bit i+1 of
  // the sum of the low i+1 bits of each operand plus cin.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] ma,
                                           input logic [W-1:0] mb,
                                           input logic mc, input logic mr);
    int unsigned  mask;
    int unsigned  t;
    logic [W-1:0] s;
    logic [W-1:0] c;
    s = '0;
    c = '0;
    if (!mr) begin
      t = int'(ma) + int'(mb) + int'(mc);
      s = W'(t % (1 << W));
      for (int i = 0; i < W; i++) begin
        mask = (1 << (i + 1)) - 1;
        t    = (int'(ma) & mask) + (int'(mb) & mask) + int'(mc);
        c[i] = ((t >> (i + 1)) & 1) != 0;
      end
    end
    return {s, c};
  endfunction

  // Apply one set of inputs ahead of the next rising edge. A throw-away
  // value is driven first to show mid-cycle input changes are ignored.
  task automatic drive(input logic r, input logic [W-1:0] da,
                       input logic [W-1:0] db, input logic dc,
                       input logic [W-1:0] es, input logic [W-1:0] ec,
                       input string nm);
    @(negedge clk);
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    #1;
    rst = r;
    a   = da;
    b   = db;
    cin = dc;
    q_sum.push_back(es);
    q_cout.push_back(ec);
    q_name.push_back(nm);
  endtask

  // Monitor: compare the registered outputs shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q_sum.size() > 0) begin
      logic [W-1:0] es;
      logic [W-1:0] ec;
      string        nm;
      es = q_sum.pop_front();
      ec = q_cout.pop_front();
      nm = q_name.pop_front();
      n_checks++;
      if (sum === es && cout === ec) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got sum=%b cout=%b, expected sum=%b cout=%b",
                 nm, sum, cout, es, ec);
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rr;
    logic [2*W-1:0] e;
    int           waited;

    rst = 1'b1;
    a   = '0;
    b   = '0;
    cin = 1'b0;

    // Reset with all-ones operands must still clear the outputs.
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, "reset_edge0");
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, "reset_edge1");

    // Directed vectors with hand-derived results.
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "zero");
    drive(1'b0, 4'b0010, 4'b0001, 1'b0, 4'b0011, 4'b0000, "2plus1");
    drive(1'b0, 4'b0011, 4'b0101, 1'b1, 4'b1001, 4'b0111, "3plus5plus1");
    drive(1'b0, 4'b0111, 4'b0111, 1'b1, 4'b1111, 4'b0111, "7plus7plus1");
    drive(1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b1111, "overflow_ripple");
    drive(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, "max_inputs");
    drive(1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b1000, "msb_only_carry");
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000, "cin_only");
    // Reset in the middle of traffic discards the in-flight result.
    drive(1'b1, 4'b1010, 4'b0110, 1'b1, 4'b0000, 4'b0000, "midreset_directed");
    drive(1'b0, 4'b0101, 4'b0101, 1'b0, 4'b1010, 4'b0101, "post_reset_first");

    // Randomized traffic with a two-cycle reset pulse in the middle.
    for (int i = 0; i < 1100; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rr = (i == 500 || i == 501);
      e  = model(ra, rb, rc, rr);
      drive(rr, ra, rb, rc, e[2*W-1:W], e[W-1:0], rr ? "random_reset" : "random");
    end

    // Let the monitor drain the scoreboard, bounded.
    waited = 0;
    while (q_sum.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q_sum.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", q_sum.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
